// File: rtl/hub_cmd_sequencer.sv
// Queues host commands and plays them into a capture core with strobe/ack handshaking.
// Optional ack timeout with ABORT issue is enabled by defining HUB_SEQ_TIMEOUT_EN.
module hub_cmd_sequencer #(
    parameter int NUM_REGS     = 8,
    parameter int REG_W        = 8,
    parameter int DEPTH        = 4,
    parameter int START_DELAY  = 50,
    parameter int TIMEOUT_CLKS = 1024,
    parameter int ACK_BIT      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [7:0]                req_cmd,
    input  logic [NUM_REGS*REG_W-1:0] req_regs,
    output logic [7:0]                command,
    output logic                      commandStrobe,
    output logic [NUM_REGS*REG_W-1:0] regIn,
    input  logic [NUM_REGS*REG_W-1:0] regOut,
    input  logic [7:0]                status,
    output logic                      rsp_valid,
    output logic [NUM_REGS*REG_W-1:0] rsp_regs,
    output logic [7:0]                rsp_status,
    output logic                      rsp_timeout,
    output logic                      busy
);
    localparam int RW = NUM_REGS * REG_W;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(START_DELAY + 2);
    localparam logic [SW-1:0] START_DONE = SW'(START_DELAY + 1);
    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_ABORT = 8'h02;
    localparam logic [7:0] CMD_ACK   = 8'h08;

    typedef enum logic [2:0] {IDLE, STROBE, WAIT_ACK, ACK_STROBE, WAIT_CLR} state_t;
    state_t state, state_next;

    logic [7:0]    fifo_cmd  [DEPTH];
    logic [RW-1:0] fifo_regs [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] start_cnt;
    logic          push, pop, ack, started, tmo_expired, ack_rsp, tmo_rsp;

    assign req_ready = (count != (AW+1)'(DEPTH));
    assign push      = req_valid && req_ready;
    assign ack       = status[ACK_BIT];
    assign started   = (start_cnt == START_DONE);
    assign busy      = (state != IDLE) || (count != '0);

    // NOTE: payload storage carries no reset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr]  <= req_cmd;
            fifo_regs[wr_ptr] <= req_regs;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            start_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!started) start_cnt <= start_cnt + 1'b1;
        end
    end

`ifdef HUB_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_expired = ((tmo_cnt + 1'b1) == TW'(TIMEOUT_CLKS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == STROBE)        tmo_cnt <= '0;
            else if (state == WAIT_ACK) tmo_cnt <= tmo_cnt + 1'b1;
            if (ack_rsp)      rsp_timeout <= 1'b0;
            else if (tmo_rsp) rsp_timeout <= 1'b1;
        end
    end
`else
    assign tmo_expired = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ack_rsp    = 1'b0;
        tmo_rsp    = 1'b0;
        unique case (state)
            // The strobe check keeps an issue from abutting the ABORT strobe.
            IDLE: if (count != '0 && started && !commandStrobe) begin
                pop        = 1'b1;
                state_next = STROBE;
            end
            STROBE: state_next = WAIT_ACK;
            WAIT_ACK: if (ack) begin
                ack_rsp    = 1'b1;
                state_next = ACK_STROBE;
            end else if (tmo_expired) begin
                tmo_rsp    = 1'b1;
                state_next = IDLE;
            end
            ACK_STROBE: state_next = WAIT_CLR;
            WAIT_CLR:   if (!ack) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Strobe and response are single-cycle pulses that fall back low by default.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            command       <= CMD_NOP;
            commandStrobe <= 1'b0;
            regIn         <= '0;
            rsp_valid     <= 1'b0;
            rsp_regs      <= '0;
            rsp_status    <= '0;
        end else begin
            commandStrobe <= 1'b0;
            rsp_valid     <= 1'b0;
            if (pop) begin
                command       <= fifo_cmd[rd_ptr];
                regIn         <= fifo_regs[rd_ptr];
                commandStrobe <= 1'b1;
            end
            if (ack_rsp) begin
                rsp_regs      <= regOut;
                rsp_status    <= status;
                rsp_valid     <= 1'b1;
                command       <= CMD_ACK;
                commandStrobe <= 1'b1;
            end
            if (tmo_rsp) begin
                rsp_status    <= status;
                rsp_valid     <= 1'b1;
                command       <= CMD_ABORT;
                commandStrobe <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hub_cmd_sequencer.sv
// Scoreboard bench for hub_cmd_sequencer; timeout scenarios run when HUB_SEQ_TIMEOUT_EN is defined.
module tb_hub_cmd_sequencer;
    localparam logic [7:0] CMD_ABORT = 8'h02;
    localparam logic [7:0] CMD_ACK   = 8'h08;
    localparam int SEL_ISSUE = 0;
    localparam int SEL_ACK   = 1;
    localparam int SEL_ABORT = 2;
    localparam int SEL_RSP   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [7:0]  req_cmd, command, status, rsp_status;
    logic [63:0] req_regs, regIn, regOut, rsp_regs;
    logic        commandStrobe, rsp_valid, rsp_timeout, busy;

    hub_cmd_sequencer #(
        .NUM_REGS(8), .REG_W(8), .DEPTH(4), .START_DELAY(50), .TIMEOUT_CLKS(16), .ACK_BIT(3)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_regs(req_regs), .command(command),
        .commandStrobe(commandStrobe), .regIn(regIn), .regOut(regOut), .status(status),
        .rsp_valid(rsp_valid), .rsp_regs(rsp_regs), .rsp_status(rsp_status),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] cmd; logic [63:0] regs;} issue_t;
    typedef struct packed {logic [63:0] regs; logic [7:0] status; logic timeout;} rsp_t;

    issue_t exp_issue[$];
    rsp_t   exp_rsp[$];
    issue_t it;
    rsp_t   rp;

    int n_checks = 0, n_fail = 0;
    int n_issue, n_ack, n_abort, n_rsp;
    int cyc, first_issue_cyc, last_issue_cyc, last_rsp_cyc;
    logic prev_strobe = 1'b0;
    logic [63:0] model_rsp_regs;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: sample mid-cycle, pop expectations on each strobe or response.
    always @(negedge clk) begin
        if (reset) begin
            prev_strobe = 1'b0;
        end else begin
            if (commandStrobe) begin
                check("strobe_gap", prev_strobe, 1'b0);
                if (command == CMD_ACK) n_ack++;
                else if (command == CMD_ABORT) n_abort++;
                else begin
                    n_issue++;
                    last_issue_cyc = cyc;
                    if (first_issue_cyc == 0) first_issue_cyc = cyc;
                    if (exp_issue.size() == 0) check("unexpected_issue", command, 8'hff);
                    else begin
                        it = exp_issue.pop_front();
                        check("issue_cmd", command, it.cmd);
                        check("issue_regs", regIn, it.regs);
                    end
                end
            end
            if (rsp_valid) begin
                n_rsp++;
                last_rsp_cyc = cyc;
                if (exp_rsp.size() == 0) check("unexpected_rsp", rsp_status, 9'h100);
                else begin
                    rp = exp_rsp.pop_front();
                    check("rsp_regs", rsp_regs, rp.regs);
                    check("rsp_status", rsp_status, rp.status);
                    check("rsp_timeout", rsp_timeout, rp.timeout);
                    check("rsp_cmd", {commandStrobe, command}, {1'b1, rp.timeout ? CMD_ABORT : CMD_ACK});
                end
            end
            prev_strobe = commandStrobe;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int get_cnt(input int sel);
        case (sel)
            SEL_ISSUE: return n_issue;
            SEL_ACK:   return n_ack;
            SEL_ABORT: return n_abort;
            default:   return n_rsp;
        endcase
    endfunction

    task automatic wait_cnt(input int sel, input int target, input int budget, input string tag);
        int i = 0;
        while (get_cnt(sel) < target && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, get_cnt(sel) >= target, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_command"}, command, 8'h00);
        check({tag, "_strobe"}, commandStrobe, 1'b0);
        check({tag, "_regIn"}, regIn, 64'h0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_regs"}, rsp_regs, 64'h0);
        check({tag, "_rsp_status"}, rsp_status, 8'h00);
        check({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_req_ready"}, req_ready, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        status = 8'h00;
        regOut = 64'h0;
        exp_issue.delete();
        exp_rsp.delete();
        n_issue = 0; n_ack = 0; n_abort = 0; n_rsp = 0;
        first_issue_cyc = 0; last_issue_cyc = 0; last_rsp_cyc = 0;
        model_rsp_regs = 64'h0;
        tick(2);
        check_reset_outputs("rst");
        reset = 1'b0;
    endtask

    // Holds req_valid until accepted; acc_cyc is the cycle index seen just before the accepting edge.
    task automatic push_cmd(input logic [7:0] c, input logic [63:0] r, input int budget, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc = -1;
        req_valid = 1'b1;
        req_cmd = c;
        req_regs = r;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_issue.push_back({c, r});
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        tick(1);
        req_valid = 1'b0;
        check("push_accept", done, 1'b1);
    endtask

    task automatic give_ack(input logic [63:0] r, input logic [7:0] st);
        regOut = r;
        status = st | 8'h08;
        exp_rsp.push_back({r, st | 8'h08, 1'b0});
        model_rsp_regs = r;
    endtask

    task automatic serve(input int first, input int n);
        logic [7:0] st;
        for (int k = 0; k < n; k++) begin
            wait_cnt(SEL_ISSUE, first + k, 120, "serve_issue");
            st = 8'($urandom);
            give_ack({$urandom, $urandom}, st);
            wait_cnt(SEL_RSP, first + k, 20, "serve_rsp");
            status = 8'h00;
        end
    endtask

    int acc, c0, guard;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_cmd = 8'h00; req_regs = 64'h0;
        regOut = 64'h0; status = 8'h00;
        #1 check_reset_outputs("por");

        // Single command: issue at cycle 52, one response, one ACK strobe.
        do_reset();
        push_cmd(8'h04, {48'h0, 8'd110, 8'd20}, 10, acc);
        wait_cnt(SEL_ISSUE, 1, 100, "t27_issue");
        check("t27_issue_cycle", first_issue_cyc, 52);
        tick(5);
        give_ack(64'h0123_4567_89ab_cdef, 8'h81);
        wait_cnt(SEL_RSP, 1, 20, "t27_rsp");
        status = 8'h00;
        tick(5);
        check("t27_rsp_count", n_rsp, 1);
        check("t27_ack_count", n_ack, 1);
        check("t27_abort_count", n_abort, 0);
        check("t27_busy_idle", busy, 1'b0);

        // Back-to-back fill: full after four, fifth waits for the first pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_cmd(8'h10 + 8'(i), {$urandom, $urandom}, 5, acc);
            check("t28_accept_cycle", acc, i);
        end
        check("t28_full_ready", req_ready, 1'b0);
        check("t28_full_busy", busy, 1'b1);
        push_cmd(8'h20, {$urandom, $urandom}, 100, acc);
        check("t28_fifth_cycle", acc, 52);
        serve(1, 5);
        tick(5);
        check("t28_rsp_count", n_rsp, 5);
        check("t28_drained", busy, 1'b0);

        // Ack held high after the ACK strobe blocks the next issue until it drops.
        do_reset();
        push_cmd(8'h31, {$urandom, $urandom}, 5, acc);
        push_cmd(8'h32, {$urandom, $urandom}, 5, acc);
        wait_cnt(SEL_ISSUE, 1, 100, "t30_issue1");
        give_ack({$urandom, $urandom}, 8'h08);
        wait_cnt(SEL_ACK, 1, 20, "t30_ack");
        tick(10);
        check("t30_hold_no_issue", n_issue, 1);
        status = 8'h00;
        c0 = cyc;
        wait_cnt(SEL_ISSUE, 2, 10, "t30_issue2");
        check("t30_issue2_cycle", last_issue_cyc, c0 + 2);
        serve(2, 1);

        // Asynchronous reset in WAIT_ACK with two queued drops everything.
        do_reset();
        for (int i = 0; i < 3; i++) push_cmd(8'h40 + 8'(i), {$urandom, $urandom}, 5, acc);
        wait_cnt(SEL_ISSUE, 1, 100, "t31_issue");
        tick(3);
        #2 reset = 1'b1;
        #1 check_reset_outputs("t31_async");
        do_reset();
        push_cmd(8'h55, {$urandom, $urandom}, 5, acc);
        guard = 0;
        while (cyc < 51 && guard < 80) begin tick(1); guard++; end
        check("t31_quiet_issue", n_issue, 0);
        check("t31_quiet_rsp", n_rsp, 0);
        wait_cnt(SEL_ISSUE, 1, 10, "t31_issue_new");
        check("t31_issue_cycle", first_issue_cyc, 52);
        serve(1, 1);

`ifdef HUB_SEQ_TIMEOUT_EN
        // Timeout after 16 WAIT_ACK cycles, ABORT strobed, queue continues.
        do_reset();
        for (int i = 0; i < 3; i++) push_cmd(8'h60 + 8'(i), {$urandom, $urandom}, 5, acc);
        wait_cnt(SEL_ISSUE, 1, 100, "t29_issue1");
        give_ack(64'hfeed_0000_beef_1111, 8'h00);
        wait_cnt(SEL_RSP, 1, 20, "t29_rsp1");
        status = 8'h51;
        wait_cnt(SEL_ISSUE, 2, 20, "t29_issue2");
        c0 = last_issue_cyc;
        exp_rsp.push_back({model_rsp_regs, 8'h51, 1'b1});
        wait_cnt(SEL_RSP, 2, 40, "t29_rsp2");
        check("t29_timeout_cycle", last_rsp_cyc, c0 + 17);
        check("t29_abort_count", n_abort, 1);
        check("t29_timeout_flag", rsp_timeout, 1'b1);
        serve(3, 1);
        tick(5);
        check("t29_abort_once", n_abort, 1);
        check("t29_ack_count", n_ack, 2);

        // Ack arriving on the expiry edge wins over the timeout.
        do_reset();
        push_cmd(8'h71, {$urandom, $urandom}, 5, acc);
        wait_cnt(SEL_ISSUE, 1, 100, "t32_issue");
        c0 = last_issue_cyc;
        guard = 0;
        while (cyc < c0 + 16 && guard < 40) begin tick(1); guard++; end
        give_ack({$urandom, $urandom}, 8'h20);
        wait_cnt(SEL_RSP, 1, 10, "t32_rsp");
        check("t32_rsp_cycle", last_rsp_cyc, c0 + 17);
        status = 8'h00;
        tick(5);
        check("t32_no_abort", n_abort, 0);
        check("t32_ack_once", n_ack, 1);
`else
        // Without the timeout build, WAIT_ACK waits indefinitely.
        do_reset();
        push_cmd(8'h71, {$urandom, $urandom}, 5, acc);
        wait_cnt(SEL_ISSUE, 1, 100, "t26_issue");
        tick(40);
        check("t26_no_rsp", n_rsp, 0);
        check("t26_no_abort", n_abort, 0);
        check("t26_timeout_low", rsp_timeout, 1'b0);
        check("t26_busy", busy, 1'b1);
        serve(1, 1);
`endif

        tick(3);
        check("issue_queue_empty", exp_issue.size(), 0);
        check("rsp_queue_empty", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hub_cmd_sequencer.md
HUB_CMD_SEQUENCER -- requirements
Module: hub_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: count of regIn/regOut registers.
REQ-002 SHALL have parameter REG_W, default 8: register width in bits.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2, min 2): command FIFO entries.
REQ-004 SHALL have parameter START_DELAY, default 50: clocks after reset before first issue.
REQ-005 SHALL have parameter TIMEOUT_CLKS, default 1024: ack wait limit.
REQ-006 SHALL have parameter ACK_BIT, default 3: status bit carrying ack.
REQ-007 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  host command request.
- req_ready  out  1  FIFO not full.
- req_cmd  in  8  function code.
- req_regs  in  NUM_REGS*REG_W  payload; reg i at bits [i*REG_W +: REG_W].
- command  out  8  function code to capture core.
- commandStrobe  out  1  one-cycle command qualifier.
- regIn  out  NUM_REGS*REG_W  registers to core.
- regOut  in  NUM_REGS*REG_W  registers from core.
- status  in  8  core status.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_regs  out  NUM_REGS*REG_W  captured regOut.
- rsp_status  out  8  captured status.
- rsp_timeout  out  1  response is a timeout.
- busy  out  1  state not IDLE or FIFO non-empty.

Function
REQ-008 Codes SHALL be: NOP 0x00, ABORT 0x02, ACK 0x08.
REQ-009 Push SHALL occur on clk when req_valid && req_ready; req_ready = !full from registered count.
- Pop in the same cycle does not enable a push when full.
REQ-010 Startup counter SHALL count from 0 after reset, saturate, and gate issue until count > START_DELAY.
REQ-011 States SHALL be IDLE, STROBE, WAIT_ACK, ACK_STROBE, WAIT_CLR.
REQ-012 IDLE: FIFO non-empty and startup elapsed at edge T -> pop; at T+1 command=req_cmd, regIn=req_regs, commandStrobe=1; -> STROBE.
REQ-013 STROBE SHALL last one cycle: next edge commandStrobe=0, timeout counter=0; -> WAIT_ACK.
REQ-014 WAIT_ACK, status[ACK_BIT]=1 sampled at edge E SHALL produce, at E:
- rsp_regs=regOut, rsp_status=status, rsp_timeout=0, rsp_valid=1;
- command=0x08, commandStrobe=1;
- -> ACK_STROBE.
REQ-015 ACK_STROBE SHALL last one cycle: commandStrobe=0, rsp_valid=0; -> WAIT_CLR.
REQ-016 WAIT_CLR SHALL hold until status[ACK_BIT]=0, then -> IDLE; next command issues no earlier than the following edge.
REQ-017 Timeout counter SHALL increment each WAIT_ACK cycle, width ceil(log2(TIMEOUT_CLKS+1)).
REQ-018 Counter reaching TIMEOUT_CLKS without ack SHALL produce:
- rsp_valid=1, rsp_timeout=1, rsp_regs unchanged, rsp_status=status;
- command=0x02, commandStrobe=1 for one cycle;
- -> IDLE; no ack handshake.
REQ-019 Ack and timeout in the same cycle SHALL resolve as ack.
REQ-020 command and regIn SHALL hold their last value between issues; commandStrobe SHALL never be high two consecutive cycles.
REQ-021 rsp_valid SHALL be exactly one cycle per popped command.

Reset
REQ-022 Reset SHALL, asynchronously: command=0x00, commandStrobe=0, regIn=0, rsp_valid=0, rsp_regs=0, rsp_status=0, rsp_timeout=0, busy=0, req_ready=1.
REQ-023 Reset SHALL also: state=IDLE, FIFO empty, startup and timeout counters 0.
REQ-024 Reset mid-transaction SHALL discard the in-flight command and all queued commands with no response.

Configuration
REQ-025 With HUB_SEQ_TIMEOUT_EN defined, REQ-017..019 SHALL apply.
REQ-026 Without HUB_SEQ_TIMEOUT_EN, timeout logic SHALL be absent, WAIT_ACK waits indefinitely, and rsp_timeout SHALL be tied 0.

Verification
REQ-027 Push 0x04 with regs {20,110}-packed, ack after 5 clks -> strobe at cycle 52 after reset release, rsp_valid once, command 0x08 strobed once.
REQ-028 Push 5 commands back-to-back into DEPTH=4 with ack held 0 -> req_ready low after 4th accepted; 5th accepted only after a pop.
REQ-029 Macro defined, TIMEOUT_CLKS=16, no ack -> rsp_timeout=1 after 16 WAIT_ACK cycles, 0x02 strobed once, next command issues.
REQ-030 Ack held high 10 cycles after ACK strobe -> no new strobe until ack low, then next command issues the following edge.
REQ-031 Reset asserted in WAIT_ACK with 2 queued -> all outputs at reset values immediately; no strobes after release until START_DELAY.
REQ-032 Ack rises the same cycle as timeout expiry -> rsp_timeout=0, 0x08 strobed, 0x02 never strobed.
